// File: rtl/pipeline_fetch_unit_pkg.sv
// Shared definitions for the IF-stage fetch unit: FSM states, redirect
// kinds, the trap opcode and the NOP word injected while draining.
package pipeline_defs;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } fetch_state_e;

    localparam logic [1:0]  BR_REL   = 2'b00;
    localparam logic [1:0]  BR_JUMP  = 2'b01;
    localparam logic [1:0]  BR_JREG  = 2'b10;

    localparam logic [5:0]  OPC_TRAP = 6'h11;
    localparam logic [31:0] NOP      = 32'h0000_0000;

endpackage

// File: rtl/pipeline_fetch_unit_next_pc_sel.sv
// Redirect target adders and the next-PC mux (hold / sequential / branch /
// jump / jump-register).
module next_pc_sel
    import pipeline_defs::*;
(
    input  logic [31:0] pc_i,
    input  logic        pcWr_i,
    input  logic        branch_i,
    input  logic [1:0]  branchType_i,
    input  logic [31:0] pcPlus4Id_i,
    input  logic [31:0] extendedImm_i,
    input  logic [31:0] registerS1_i,
    input  logic [31:0] instructionId_i,
    output logic [31:0] pcPlus4_o,
    output logic [31:0] nextPc_o
);

    logic [31:0] relTarget;
    logic [31:0] jumpTarget;
    logic [31:0] target;
    logic        unusedOpcodeBits;

    assign pcPlus4_o  = pc_i + 32'd4;
    assign relTarget  = pcPlus4Id_i + extendedImm_i;
    assign jumpTarget = pcPlus4Id_i + {{6{instructionId_i[25]}}, instructionId_i[25:0]};

    // Only the 26-bit jump offset of the ID-stage instruction matters here.
    assign unusedOpcodeBits = ^instructionId_i[31:26];

    always_comb begin
        target = relTarget;
        case (branchType_i)
            BR_JUMP: target = jumpTarget;
            BR_JREG: target = registerS1_i;
            default: target = relTarget;
        endcase
    end

    // A resolved redirect wins over a stall; targets are forced word-aligned.
    always_comb begin
        nextPc_o = pc_i;
        if (branch_i) begin
            nextPc_o = {target[31:2], 2'b00};
        end else if (pcWr_i) begin
            nextPc_o = pcPlus4_o;
        end
    end

endmodule

// File: rtl/pipeline_fetch_unit.sv
// IF-stage front end: PC register, next-PC selection and the trap-driven
// drain sequence that ends the program.
module pipeline_fetch_unit
    import pipeline_defs::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [5:0]  TRAP_OPCODE  = OPC_TRAP,
    parameter int          DRAIN_CYCLES = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcWr,
    input  logic        branch,
    input  logic [1:0]  branchType,
    input  logic [31:0] pcPlus4Id,
    input  logic [31:0] extendedImmIn,
    input  logic [31:0] registerS1In,
    input  logic [31:0] instructionIdIn,
    input  logic [31:0] imemData,
    output logic [31:0] imemAddr,
    output logic [31:0] pcPlus4,
    output logic [31:0] preInstruction,
    output logic        endProgram,
    output logic        draining
);

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [3:0]   drainCnt_q, drainCnt_d;
    logic         endProgram_q;
    logic [31:0]  nextPc;
    logic         trapAccept;

    next_pc_sel u_next_pc_sel (
        .pc_i            (pc_q),
        .pcWr_i          (pcWr),
        .branch_i        (branch),
        .branchType_i    (branchType),
        .pcPlus4Id_i     (pcPlus4Id),
        .extendedImm_i   (extendedImmIn),
        .registerS1_i    (registerS1In),
        .instructionId_i (instructionIdIn),
        .pcPlus4_o       (pcPlus4),
        .nextPc_o        (nextPc)
    );

    // A trap only counts once it is really written into IF/ID and not squashed.
    assign trapAccept = (imemData[31:26] == TRAP_OPCODE) && pcWr && !branch;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        drainCnt_d     = drainCnt_q;
        preInstruction = NOP;
        case (state_q)
            RUN: begin
                preInstruction = imemData;
                if (trapAccept) begin
                    state_d    = DRAIN;
                    drainCnt_d = DRAIN_INIT;
                end else begin
                    pc_d = nextPc;
                end
            end
            DRAIN: begin
                drainCnt_d = drainCnt_q - 4'd1;
                if (drainCnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            drainCnt_q   <= 4'd0;
            endProgram_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drainCnt_q   <= drainCnt_d;
            endProgram_q <= (state_q == DONE);
        end
    end

    assign imemAddr   = pc_q;
    assign endProgram = endProgram_q;
    assign draining   = (state_q == DRAIN);

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Self-checking bench for pipeline_fetch_unit against a timestamp-based
// reference model of PC flow and the trap drain sequence.
module tb_pipeline_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DRAIN    = 5;
    localparam logic [31:0] TRAP     = {6'h11, 26'h0};

    logic        clk;
    logic        reset;
    logic        pcWr;
    logic        branch;
    logic [1:0]  branchType;
    logic [31:0] pcPlus4Id;
    logic [31:0] extendedImmIn;
    logic [31:0] registerS1In;
    logic [31:0] instructionIdIn;
    logic [31:0] imemData;
    logic [31:0] imemAddr;
    logic [31:0] pcPlus4;
    logic [31:0] preInstruction;
    logic        endProgram;
    logic        draining;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mPc;
    bit          mAccepted;
    int          mSince;

    pipeline_fetch_unit #(
        .RESET_PC     (RESET_PC),
        .TRAP_OPCODE  (6'h11),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pcWr            (pcWr),
        .branch          (branch),
        .branchType      (branchType),
        .pcPlus4Id       (pcPlus4Id),
        .extendedImmIn   (extendedImmIn),
        .registerS1In    (registerS1In),
        .instructionIdIn (instructionIdIn),
        .imemData        (imemData),
        .imemAddr        (imemAddr),
        .pcPlus4         (pcPlus4),
        .preInstruction  (preInstruction),
        .endProgram      (endProgram),
        .draining        (draining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] randInstr();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h11) w[31:26] = 6'h00;
        return w;
    endfunction

    function automatic logic [31:0] modelTarget();
        longint off;
        longint t;
        case (branchType)
            2'b01: begin
                off = longint'(instructionIdIn[25:0]);
                if (instructionIdIn[25]) off = off - 64'sd67108864;
                t = longint'(pcPlus4Id) + off;
            end
            2'b10:   t = longint'(registerS1In);
            default: t = longint'(pcPlus4Id) + longint'(extendedImmIn);
        endcase
        return {t[31:2], 2'b00};
    endfunction

    // Model: once a trap is accepted, everything is a function of edges since.
    task automatic modelStep();
        if (reset) begin
            mPc       = RESET_PC;
            mAccepted = 0;
            mSince    = 0;
        end else if (mAccepted) begin
            mSince++;
        end else if (branch) begin
            mPc = modelTarget();
        end else if (pcWr && imemData[31:26] == 6'h11) begin
            mAccepted = 1;
            mSince    = 0;
        end else if (pcWr) begin
            mPc = mPc + 32'd4;
        end
    endtask

    function automatic logic expDraining();
        return mAccepted && (mSince < DRAIN);
    endfunction

    function automatic logic expEnd();
        return mAccepted && (mSince >= DRAIN + 1);
    endfunction

    function automatic logic [31:0] expPre();
        return mAccepted ? 32'h0 : imemData;
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pcWr = 1'b1; branch = 1'b1; branchType = 2'b10;
        registerS1In = 32'h1234_5678; imemData = TRAP;
        tick();
        tick();
        checks++; if (imemAddr !== RESET_PC) begin failures++; $display("[TB] FAIL reset_imemAddr got=%h exp=%h", imemAddr, RESET_PC); end
        checks++; if (pcPlus4 !== RESET_PC + 32'd4) begin failures++; $display("[TB] FAIL reset_pcPlus4 got=%h exp=%h", pcPlus4, RESET_PC + 32'd4); end
        checks++; if (endProgram !== 1'b0) begin failures++; $display("[TB] FAIL reset_endProgram got=%b exp=0", endProgram); end
        checks++; if (draining !== 1'b0) begin failures++; $display("[TB] FAIL reset_draining got=%b exp=0", draining); end
        reset = 1'b0; branch = 1'b0; pcWr = 1'b0; imemData = randInstr();
    endtask

    task automatic test_free_run();
        pcWr = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            imemData = randInstr();
            tick();
            checks++; if (imemAddr !== 32'(4 * i) || imemAddr !== mPc) begin failures++; $display("[TB] FAIL run_imemAddr step=%0d got=%h exp=%h", i, imemAddr, 32'(4 * i)); end
            checks++; if (pcPlus4 !== mPc + 32'd4) begin failures++; $display("[TB] FAIL run_pcPlus4 got=%h exp=%h", pcPlus4, mPc + 32'd4); end
            checks++; if (preInstruction !== expPre()) begin failures++; $display("[TB] FAIL run_preInstr got=%h exp=%h", preInstruction, expPre()); end
            checks++; if (endProgram !== 1'b0) begin failures++; $display("[TB] FAIL run_endProgram got=%b exp=0", endProgram); end
        end
    endtask

    task automatic test_stall_branch();
        pcWr = 1'b1;
        tick();
        checks++; if (imemAddr !== 32'h10) begin failures++; $display("[TB] FAIL pre_stall_pc got=%h exp=%h", imemAddr, 32'h10); end
        pcWr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (imemAddr !== 32'h10) begin failures++; $display("[TB] FAIL stall_hold got=%h exp=%h", imemAddr, 32'h10); end
        end
        branch = 1'b1; branchType = 2'b00; pcPlus4Id = 32'h10; extendedImmIn = 32'hFFFF_FFF8;
        tick();
        checks++; if (imemAddr !== 32'h8 || imemAddr !== mPc) begin failures++; $display("[TB] FAIL stalled_branch got=%h exp=%h", imemAddr, 32'h8); end
        pcWr = 1'b1; pcPlus4Id = 32'h104; extendedImmIn = 32'h100;
        tick();
        checks++; if (imemAddr !== 32'h204) begin failures++; $display("[TB] FAIL branch_fwd got=%h exp=%h", imemAddr, 32'h204); end
        branch = 1'b0;
    endtask

    task automatic test_jumps();
        pcWr = 1'b1; branch = 1'b1;
        branchType = 2'b01; pcPlus4Id = 32'h20; instructionIdIn = {6'h2A, 26'h3FF_FFFC};
        tick();
        checks++; if (imemAddr !== 32'h1C || imemAddr !== mPc) begin failures++; $display("[TB] FAIL jump_rel got=%h exp=%h", imemAddr, 32'h1C); end
        branchType = 2'b10; registerS1In = 32'h1003;
        tick();
        checks++; if (imemAddr !== 32'h1000) begin failures++; $display("[TB] FAIL jump_reg got=%h exp=%h", imemAddr, 32'h1000); end
        branchType = 2'b11; pcPlus4Id = 32'h50; extendedImmIn = 32'h6;
        tick();
        checks++; if (imemAddr !== 32'h54) begin failures++; $display("[TB] FAIL type11_as_rel got=%h exp=%h", imemAddr, 32'h54); end
        branch = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            pcWr            = 1'($urandom);
            branch          = ($urandom_range(0, 4) == 0);
            branchType      = 2'($urandom);
            pcPlus4Id       = $urandom;
            extendedImmIn   = $urandom;
            registerS1In    = $urandom;
            instructionIdIn = $urandom;
            imemData        = randInstr();
            tick();
            checks++; if (imemAddr !== mPc) begin failures++; $display("[TB] FAIL rand_imemAddr iter=%0d got=%h exp=%h", i, imemAddr, mPc); end
            checks++; if (pcPlus4 !== mPc + 32'd4) begin failures++; $display("[TB] FAIL rand_pcPlus4 iter=%0d got=%h exp=%h", i, pcPlus4, mPc + 32'd4); end
            checks++; if (preInstruction !== expPre()) begin failures++; $display("[TB] FAIL rand_preInstr iter=%0d got=%h exp=%h", i, preInstruction, expPre()); end
            checks++; if (draining !== expDraining()) begin failures++; $display("[TB] FAIL rand_draining iter=%0d got=%b exp=%b", i, draining, expDraining()); end
        end
        branch = 1'b0;
    endtask

    task automatic test_trap();
        branch = 1'b1; branchType = 2'b10; registerS1In = 32'h40; pcWr = 1'b1;
        imemData = randInstr();
        tick();
        branch = 1'b0;
        checks++; if (imemAddr !== 32'h40) begin failures++; $display("[TB] FAIL trap_setup_pc got=%h exp=%h", imemAddr, 32'h40); end
        imemData = TRAP;
        tick();
        for (int k = 0; k < DRAIN; k++) begin
            checks++; if (draining !== 1'b1 || draining !== expDraining()) begin failures++; $display("[TB] FAIL drain_flag cyc=%0d got=%b exp=1", k, draining); end
            checks++; if (preInstruction !== 32'h0) begin failures++; $display("[TB] FAIL drain_nop cyc=%0d got=%h exp=0", k, preInstruction); end
            checks++; if (imemAddr !== 32'h40) begin failures++; $display("[TB] FAIL drain_pc cyc=%0d got=%h exp=%h", k, imemAddr, 32'h40); end
            checks++; if (endProgram !== 1'b0) begin failures++; $display("[TB] FAIL drain_end_early cyc=%0d got=%b exp=0", k, endProgram); end
            pcWr = 1'($urandom); branch = 1'($urandom); registerS1In = $urandom; imemData = $urandom;
            tick();
        end
        checks++; if (draining !== 1'b0 || endProgram !== 1'b0) begin failures++; $display("[TB] FAIL drain_gap got=%b%b exp=00", draining, endProgram); end
        tick();
        checks++; if (endProgram !== 1'b1 || endProgram !== expEnd()) begin failures++; $display("[TB] FAIL end_rise got=%b exp=1", endProgram); end
        for (int k = 0; k < 10; k++) begin
            pcWr = 1'($urandom); branch = 1'($urandom); imemData = $urandom;
            tick();
            checks++; if (endProgram !== 1'b1) begin failures++; $display("[TB] FAIL end_hold cyc=%0d got=%b exp=1", k, endProgram); end
            checks++; if (imemAddr !== 32'h40 || preInstruction !== 32'h0) begin failures++; $display("[TB] FAIL done_frozen cyc=%0d got=%h/%h exp=%h/0", k, imemAddr, preInstruction, 32'h40); end
        end
        branch = 1'b0;
    endtask

    task automatic test_reset_in_done();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (endProgram !== 1'b0) begin failures++; $display("[TB] FAIL done_reset_end got=%b exp=0", endProgram); end
        checks++; if (imemAddr !== RESET_PC || draining !== 1'b0) begin failures++; $display("[TB] FAIL done_reset_state got=%h/%b exp=%h/0", imemAddr, draining, RESET_PC); end
    endtask

    task automatic test_squash_stall();
        imemData = TRAP; branch = 1'b1; branchType = 2'b10; registerS1In = 32'h200; pcWr = 1'b1;
        tick();
        branch = 1'b0;
        checks++; if (imemAddr !== 32'h200 || draining !== 1'b0) begin failures++; $display("[TB] FAIL squashed_trap got=%h/%b exp=%h/0", imemAddr, draining, 32'h200); end
        pcWr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (draining !== 1'b0 || imemAddr !== 32'h200) begin failures++; $display("[TB] FAIL stalled_trap cyc=%0d got=%h/%b exp=%h/0", i, imemAddr, draining, 32'h200); end
        end
        pcWr = 1'b1;
        tick();
        checks++; if (draining !== 1'b1 || draining !== expDraining()) begin failures++; $display("[TB] FAIL trap_on_write got=%b exp=1", draining); end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (draining !== 1'b1) begin failures++; $display("[TB] FAIL mid_drain cyc=%0d got=%b exp=1", i, draining); end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (imemAddr !== RESET_PC || draining !== 1'b0 || endProgram !== 1'b0) begin failures++; $display("[TB] FAIL drain_reset got=%h/%b/%b exp=%h/0/0", imemAddr, draining, endProgram, RESET_PC); end
        pcWr = 1'b1; imemData = randInstr();
        tick();
        checks++; if (imemAddr !== RESET_PC + 32'd4 || preInstruction !== imemData) begin failures++; $display("[TB] FAIL run_after_reset got=%h exp=%h", imemAddr, RESET_PC + 32'd4); end
    endtask

    task automatic test_wrap();
        branch = 1'b1; branchType = 2'b10; registerS1In = 32'hFFFF_FFFF; pcWr = 1'b0;
        tick();
        branch = 1'b0;
        checks++; if (imemAddr !== 32'hFFFF_FFFC || pcPlus4 !== 32'h0) begin failures++; $display("[TB] FAIL wrap_top got=%h/%h exp=fffffffc/0", imemAddr, pcPlus4); end
        pcWr = 1'b1;
        tick();
        checks++; if (imemAddr !== 32'h0 || imemAddr !== mPc || pcPlus4 !== 32'h4) begin failures++; $display("[TB] FAIL wrap_zero got=%h/%h exp=0/4", imemAddr, pcPlus4); end
    endtask

    initial begin
        reset = 1'b1; pcWr = 1'b0; branch = 1'b0; branchType = 2'b00;
        pcPlus4Id = 32'h0; extendedImmIn = 32'h0; registerS1In = 32'h0;
        instructionIdIn = 32'h0; imemData = 32'h0;
        mPc = RESET_PC; mAccepted = 0; mSince = 0;
        test_reset();
        test_free_run();
        test_stall_branch();
        test_jumps();
        test_random();
        test_trap();
        test_reset_in_done();
        test_squash_stall();
        test_reset_mid_drain();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
